// File: rtl/jesd204_frame_mark_pkg.sv
// Shared widths and parameter checks for the JESD204 frame/multiframe marker generator.
package jesd204_frame_mark_pkg;

   // Bit j set means a data path of j octets per beat is supported.
   localparam logic [8:0] LEGAL_DPW_MASK = 9'b1_0001_0110;

   function automatic int CW_OFF(input int max_octets_per_frame);
      return (max_octets_per_frame > 2) ? $clog2(max_octets_per_frame) : 1;
   endfunction

   function automatic int CW_FRM(input int max_frames_per_multiframe);
      return (max_frames_per_multiframe > 2) ? $clog2(max_frames_per_multiframe) : 1;
   endfunction

   function automatic bit dpw_is_legal(input int dpw);
      return (dpw == 1) || (dpw == 2) || (dpw == 4) || (dpw == 8);
   endfunction

endpackage

// File: rtl/jesd204_frame_mark_lane_step.sv
// One octet lane of the marker chain: classifies the (offset, frame) position and
// produces the position of the following octet.
module jesd204_frame_mark_lane_step #(
   parameter int OFF_W = 8,
   parameter int FRM_W = 8
) (
   input  logic [OFF_W-1:0] off_in,
   input  logic [FRM_W-1:0] frm_in,
   input  logic [OFF_W-1:0] f_last,
   input  logic [FRM_W-1:0] k_last,
   output logic             sof,
   output logic             eof,
   output logic             somf,
   output logic             eomf,
   output logic [OFF_W-1:0] off_out,
   output logic [FRM_W-1:0] frm_out
);

   always_comb begin
      sof     = (off_in == '0);
      eof     = (off_in == f_last);
      somf    = sof & (frm_in == '0);
      eomf    = eof & (frm_in == k_last);
      off_out = off_in + 1'b1;
      frm_out = frm_in;
      // The last octet of a frame rolls the offset over and steps the frame index.
      if (eof) begin
         off_out = '0;
         frm_out = (frm_in == k_last) ? '0 : frm_in + 1'b1;
      end
   end

endmodule

// File: rtl/jesd204_frame_mark_generator.sv
// Per-octet sof/eof/somf/eomf generator aligned to the LMFC edge, with misalignment flagging.
// Optional saturating error counter enabled by defining JESD204_FRAME_MARK_ERR_CNT_EN.
module jesd204_frame_mark_generator
   import jesd204_frame_mark_pkg::*;
#(
   parameter int DATA_PATH_WIDTH           = 4,
   parameter int MAX_OCTETS_PER_FRAME      = 256,
   parameter int MAX_FRAMES_PER_MULTIFRAME = 256
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       lmfc_edge,
   input  logic [7:0]                 cfg_octets_per_frame,
   input  logic [7:0]                 cfg_frames_per_multiframe,
   input  logic                       cfg_generate_mf,
   output logic [DATA_PATH_WIDTH-1:0] sof,
   output logic [DATA_PATH_WIDTH-1:0] eof,
   output logic [DATA_PATH_WIDTH-1:0] somf,
   output logic [DATA_PATH_WIDTH-1:0] eomf,
   output logic                       aligned,
   output logic                       lmfc_err,
   output logic [7:0]                 lmfc_err_cnt
);

   localparam int DPW   = DATA_PATH_WIDTH;
   localparam int OFF_W = CW_OFF(MAX_OCTETS_PER_FRAME);
   localparam int FRM_W = CW_FRM(MAX_FRAMES_PER_MULTIFRAME);

   if (!dpw_is_legal(DATA_PATH_WIDTH)) begin : g_illegal_dpw
      $error("DATA_PATH_WIDTH must be 1, 2, 4 or 8");
   end

   logic [OFF_W-1:0] f_last;
   logic [FRM_W-1:0] k_last;
   logic [OFF_W-1:0] off_q, off_d;
   logic [FRM_W-1:0] frm_q, frm_d;
   logic [DPW-1:0]   sof_q, sof_d, eof_q, eof_d, somf_q, somf_d, eomf_q, eomf_d;
   logic [DPW-1:0]   sof_c, eof_c, somf_c, eomf_c;
   logic             aligned_q, aligned_d;
   logic             lmfc_err_q, lmfc_err_d;

   logic [OFF_W-1:0] off_chain [DPW+1];
   logic [FRM_W-1:0] frm_chain [DPW+1];

   assign f_last = cfg_octets_per_frame[OFF_W-1:0];
   assign k_last = cfg_frames_per_multiframe[FRM_W-1:0];

   // An LMFC edge forces the upcoming beat to start a multiframe.
   assign off_chain[0] = lmfc_edge ? '0 : off_q;
   assign frm_chain[0] = lmfc_edge ? '0 : frm_q;

   for (genvar j = 0; j < DPW; j++) begin : g_lane
      jesd204_frame_mark_lane_step #(
         .OFF_W (OFF_W),
         .FRM_W (FRM_W)
      ) u_step (
         .off_in  (off_chain[j]),
         .frm_in  (frm_chain[j]),
         .f_last  (f_last),
         .k_last  (k_last),
         .sof     (sof_c[j]),
         .eof     (eof_c[j]),
         .somf    (somf_c[j]),
         .eomf    (eomf_c[j]),
         .off_out (off_chain[j+1]),
         .frm_out (frm_chain[j+1])
      );
   end

   always_comb begin
      aligned_d  = aligned_q | lmfc_edge;
      off_d      = off_chain[DPW];
      frm_d      = frm_chain[DPW];
      sof_d      = '0;
      eof_d      = '0;
      somf_d     = '0;
      eomf_d     = '0;
      // Markers stay quiet until the first edge establishes the multiframe phase.
      if (aligned_d) begin
         sof_d = sof_c;
         eof_d = eof_c;
         if (cfg_generate_mf) begin
            somf_d = somf_c;
            eomf_d = eomf_c;
         end
      end
      lmfc_err_d = lmfc_edge & aligned_q & ((off_q != '0) | (frm_q != '0));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         off_q      <= '0;
         frm_q      <= '0;
         sof_q      <= '0;
         eof_q      <= '0;
         somf_q     <= '0;
         eomf_q     <= '0;
         aligned_q  <= 1'b0;
         lmfc_err_q <= 1'b0;
      end else begin
         off_q      <= off_d;
         frm_q      <= frm_d;
         sof_q      <= sof_d;
         eof_q      <= eof_d;
         somf_q     <= somf_d;
         eomf_q     <= eomf_d;
         aligned_q  <= aligned_d;
         lmfc_err_q <= lmfc_err_d;
      end
   end

   assign sof      = sof_q;
   assign eof      = eof_q;
   assign somf     = somf_q;
   assign eomf     = eomf_q;
   assign aligned  = aligned_q;
   assign lmfc_err = lmfc_err_q;

`ifdef JESD204_FRAME_MARK_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Counts alongside the registered error pulse and sticks at all-ones.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (lmfc_err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_q <= 8'h00;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign lmfc_err_cnt = err_cnt_q;
`else
   assign lmfc_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_jesd204_frame_mark_generator.sv
// Directed self-checking bench for jesd204_frame_mark_generator with a 4-octet and an 8-octet instance.
module tb_jesd204_frame_mark_generator;

`ifdef JESD204_FRAME_MARK_ERR_CNT_EN
   localparam logic [7:0] EXP_CNT_AFTER_ERR = 8'd1;
`else
   localparam logic [7:0] EXP_CNT_AFTER_ERR = 8'd0;
`endif

   logic       clk;
   logic       reset;
   logic       edge_a, edge_b;
   logic [7:0] cfg_f_a, cfg_k_a, cfg_f_b, cfg_k_b;
   logic       gen_mf_a, gen_mf_b;

   logic [3:0] sof_a, eof_a, somf_a, eomf_a;
   logic       aligned_a, err_a;
   logic [7:0] cnt_a;
   logic [7:0] sof_b, eof_b, somf_b, eomf_b;
   logic       aligned_b, err_b;
   logic [7:0] cnt_b;

   int tests_run = 0;
   int tests_failed = 0;

   jesd204_frame_mark_generator #(.DATA_PATH_WIDTH(4)) dut_a (
      .clk                       (clk),
      .reset                     (reset),
      .lmfc_edge                 (edge_a),
      .cfg_octets_per_frame      (cfg_f_a),
      .cfg_frames_per_multiframe (cfg_k_a),
      .cfg_generate_mf           (gen_mf_a),
      .sof                       (sof_a),
      .eof                       (eof_a),
      .somf                      (somf_a),
      .eomf                      (eomf_a),
      .aligned                   (aligned_a),
      .lmfc_err                  (err_a),
      .lmfc_err_cnt              (cnt_a)
   );

   jesd204_frame_mark_generator #(.DATA_PATH_WIDTH(8)) dut_b (
      .clk                       (clk),
      .reset                     (reset),
      .lmfc_edge                 (edge_b),
      .cfg_octets_per_frame      (cfg_f_b),
      .cfg_frames_per_multiframe (cfg_k_b),
      .cfg_generate_mf           (gen_mf_b),
      .sof                       (sof_b),
      .eof                       (eof_b),
      .somf                      (somf_b),
      .eomf                      (eomf_b),
      .aligned                   (aligned_b),
      .lmfc_err                  (err_b),
      .lmfc_err_cnt              (cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic rst, input logic ea, input logic eb);
      reset  = rst;
      edge_a = ea;
      edge_b = eb;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic checkQuietA(input string tag);
      checkOutput({tag, "_sof"},     32'(sof_a),     32'h0);
      checkOutput({tag, "_eof"},     32'(eof_a),     32'h0);
      checkOutput({tag, "_somf"},    32'(somf_a),    32'h0);
      checkOutput({tag, "_eomf"},    32'(eomf_a),    32'h0);
      checkOutput({tag, "_aligned"}, 32'(aligned_a), 32'h0);
      checkOutput({tag, "_err"},     32'(err_a),     32'h0);
   endtask

   initial begin
      logic [3:0] sof_tbl [3];
      logic [3:0] eof_tbl [3];
      logic [3:0] somf_tbl [3];
      logic [3:0] eomf_tbl [3];

      reset = 1'b1; edge_a = 1'b0; edge_b = 1'b0;
      cfg_f_a = 8'd0; cfg_k_a = 8'd31; gen_mf_a = 1'b1;
      cfg_f_b = 8'd1; cfg_k_b = 8'd3;  gen_mf_b = 1'b0;

      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkQuietA("reset");
      checkOutput("reset_cnt", 32'(cnt_a), 32'h0);

      // F=1, K=32: every octet is a frame, eight beats per multiframe
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkQuietA("f1_pre");
      end
      for (int b = 0; b < 16; b++) begin
         applyStimulus(1'b0, b == 0, 1'b0);
         checkOutput("f1_sof",     32'(sof_a),     32'hF);
         checkOutput("f1_eof",     32'(eof_a),     32'hF);
         checkOutput("f1_somf",    32'(somf_a),    (b % 8 == 0) ? 32'h1 : 32'h0);
         checkOutput("f1_eomf",    32'(eomf_a),    (b % 8 == 7) ? 32'h8 : 32'h0);
         checkOutput("f1_aligned", 32'(aligned_a), 32'h1);
         checkOutput("f1_err",     32'(err_a),     32'h0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("f1_good_edge_err",  32'(err_a),  32'h0);
      checkOutput("f1_good_edge_somf", 32'(somf_a), 32'h1);

      // F=3, K=4: 12-octet multiframe spans three beats
      sof_tbl  = '{4'b1001, 4'b0100, 4'b0010};
      eof_tbl  = '{4'b0100, 4'b0010, 4'b1001};
      somf_tbl = '{4'b0001, 4'b0000, 4'b0000};
      eomf_tbl = '{4'b0000, 4'b0000, 4'b1000};
      cfg_f_a = 8'd2; cfg_k_a = 8'd3;
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkQuietA("f3_pre");
      end
      for (int b = 0; b < 6; b++) begin
         applyStimulus(1'b0, b == 0, 1'b0);
         checkOutput("f3_sof",  32'(sof_a),  32'(sof_tbl[b % 3]));
         checkOutput("f3_eof",  32'(eof_a),  32'(eof_tbl[b % 3]));
         checkOutput("f3_somf", 32'(somf_a), 32'(somf_tbl[b % 3]));
         checkOutput("f3_eomf", 32'(eomf_a), 32'(eomf_tbl[b % 3]));
      end

      // F=4, K=2: edge arriving on the second beat of a multiframe
      cfg_f_a = 8'd3; cfg_k_a = 8'd1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("f4_first_err",     32'(err_a),     32'h0);
      checkOutput("f4_first_aligned", 32'(aligned_a), 32'h1);
      checkOutput("f4_first_sof",     32'(sof_a),     32'h1);
      checkOutput("f4_first_eof",     32'(eof_a),     32'h8);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("f4_bad_err",     32'(err_a),     32'h1);
      checkOutput("f4_bad_sof",     32'(sof_a),     32'h1);
      checkOutput("f4_bad_somf",    32'(somf_a),    32'h1);
      checkOutput("f4_bad_eomf",    32'(eomf_a),    32'h0);
      checkOutput("f4_bad_aligned", 32'(aligned_a), 32'h1);
      checkOutput("f4_bad_cnt",     32'(cnt_a),     32'(EXP_CNT_AFTER_ERR));
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("f4_after_err",  32'(err_a),  32'h0);
      checkOutput("f4_after_eomf", 32'(eomf_a), 32'h8);
      checkOutput("f4_after_somf", 32'(somf_a), 32'h0);
      checkOutput("f4_after_cnt",  32'(cnt_a),  32'(EXP_CNT_AFTER_ERR));
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("f4_next_somf", 32'(somf_a), 32'h1);

      // Reset in the middle of a multiframe, then realign
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkQuietA("midrst");
      checkOutput("midrst_cnt", 32'(cnt_a), 32'h0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkQuietA("midrst_idle");
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("realign_sof",     32'(sof_a),     32'h1);
      checkOutput("realign_somf",    32'(somf_a),    32'h1);
      checkOutput("realign_aligned", 32'(aligned_a), 32'h1);
      checkOutput("realign_err",     32'(err_a),     32'h0);

      // DPW=8, F=2, K=4 with multiframe markers disabled
      checkOutput("b_pre_sof",     32'(sof_b),     32'h0);
      checkOutput("b_pre_aligned", 32'(aligned_b), 32'h0);
      for (int b = 0; b < 6; b++) begin
         applyStimulus(1'b0, 1'b0, b == 0);
         checkOutput("b_sof",     32'(sof_b),     32'h55);
         checkOutput("b_eof",     32'(eof_b),     32'hAA);
         checkOutput("b_somf",    32'(somf_b),    32'h0);
         checkOutput("b_eomf",    32'(eomf_b),    32'h0);
         checkOutput("b_aligned", 32'(aligned_b), 32'h1);
         checkOutput("b_err",     32'(err_b),     32'h0);
      end
      checkOutput("b_cnt", 32'(cnt_b), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
